// File: rtl/aes_v3_col_seq.sv
// Column sequencer for the saes.v3 byte-op unit: four byte ops per phase build
// SubBytes (plus round key on a final round), then an optional MixColumns phase.
module aes_v3_col_seq #(
  parameter bit PIPE_RD = 1'b0
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_dec,
  input  logic        req_last,
  input  logic [31:0] req_col,
  input  logic [31:0] req_rk,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        busy,
  output logic        unit_valid,
  output logic        unit_dec,
  output logic        unit_mix,
  output logic [1:0]  unit_bs,
  output logic [31:0] unit_rs1,
  output logic [31:0] unit_rs2,
  input  logic [31:0] unit_rd
);

  // Handshakes: a transfer occurs on a rising edge with valid and ready both high.
  // req_ready is high only in IDLE; rsp_valid only in DONE, with rsp_data held until taken.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    MIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_q;
  logic [1:0]  bs_q;
  logic [31:0] col_q;
  logic [31:0] rk_q;
  logic [31:0] sub_q;
  logic [31:0] acc_q;
  logic [31:0] rd_q;
  logic [31:0] rsp_q;
  logic        dec_q;
  logic        last_q;
  logic        cap_q;

  logic        in_op;
  logic        capture_now;
  logic [31:0] rd_use;

  assign in_op       = (state_q == SUB) || (state_q == MIX);
  // With a registered rd every op splits into an issue cycle and a capture cycle.
  assign capture_now = PIPE_RD ? cap_q : 1'b1;
  assign rd_use      = PIPE_RD ? rd_q : unit_rd;

  assign req_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign rsp_valid  = (state_q == DONE);
  assign rsp_data   = rsp_q;

  // Unit inputs are gated to zero outside the two op phases.
  assign unit_valid = in_op && !cap_q;
  assign unit_dec   = in_op && dec_q;
  assign unit_mix   = (state_q == MIX);
  assign unit_bs    = in_op ? bs_q : 2'd0;
  assign unit_rs1   = (state_q == SUB) ? col_q : ((state_q == MIX) ? sub_q : 32'd0);
  assign unit_rs2   = in_op ? acc_q : 32'd0;

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q <= IDLE;
      bs_q    <= 2'd0;
      col_q   <= 32'd0;
      rk_q    <= 32'd0;
      sub_q   <= 32'd0;
      acc_q   <= 32'd0;
      rd_q    <= 32'd0;
      rsp_q   <= 32'd0;
      dec_q   <= 1'b0;
      last_q  <= 1'b0;
      cap_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            col_q   <= req_col;
            rk_q    <= req_rk;
            dec_q   <= req_dec;
            last_q  <= req_last;
            acc_q   <= req_last ? req_rk : 32'd0;
            bs_q    <= 2'd0;
            cap_q   <= 1'b0;
            state_q <= SUB;
          end
        end
        SUB, MIX: begin
          if (!capture_now) begin
            rd_q  <= unit_rd;
            cap_q <= 1'b1;
          end else begin
            cap_q <= 1'b0;
            if (bs_q != 2'd3) begin
              acc_q <= rd_use;
              bs_q  <= bs_q + 2'd1;
            end else if ((state_q == SUB) && !last_q) begin
              // Full round: SubBytes column done, restart accumulation from the round key.
              sub_q   <= rd_use;
              acc_q   <= rk_q;
              bs_q    <= 2'd0;
              state_q <= MIX;
            end else begin
              acc_q   <= rd_use;
              rsp_q   <= rd_use;
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          if (rsp_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_v3_col_seq.sv
// Bench for aes_v3_col_seq: one instance per PIPE_RD setting, each driving a behavioural
// byte-op unit; responses are scored against a whole-column AES reference model.
module tb_aes_v3_col_seq;

  logic        g_clk = 1'b0;
  logic        g_resetn;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_dec   [2];
  logic        req_last  [2];
  logic [31:0] req_col   [2];
  logic [31:0] req_rk    [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_data  [2];
  logic        busy      [2];
  logic        unit_valid[2];
  logic        unit_dec  [2];
  logic        unit_mix  [2];
  logic [1:0]  unit_bs   [2];
  logic [31:0] unit_rs1  [2];
  logic [31:0] unit_rs2  [2];
  logic [31:0] unit_rd   [2];

  logic [7:0]  sbox     [256];
  logic [7:0]  inv_sbox [256];

  logic [31:0] exp_q[$];
  int          due_q[$];
  int          ops_q[$];
  int          op_cnt[2];
  logic        prev_v[2];
  logic        rnd_rdy;
  int          total;
  int          bad;
  int          cyc = 0;

  // ---------------- clock / reset ----------------
  always #5 g_clk = ~g_clk;
  always @(posedge g_clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish want finish by 40000 cycles");
    $fatal(1);
  end

  // ---------------- GF(2^8) and reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      logic [7:0] s;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
          ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox[x]     = s;
      inv_sbox[s] = 8'(x);
    end
  endtask

  // Byte-op unit: rd = rs2 ^ (contribution of rs1 byte bs, placed/rotated to row bs).
  function automatic logic [31:0] unit_op(input logic dec, input logic mix, input logic [1:0] bs,
                                          input logic [31:0] rs1, input logic [31:0] rs2);
    logic [7:0]  b;
    logic [31:0] t;
    logic [31:0] r;
    b = rs1[8*bs +: 8];
    if (!mix)     t = {24'h0, (dec ? inv_sbox[b] : sbox[b])};
    else if (dec) t = {gmul(b, 8'h0b), gmul(b, 8'h0d), gmul(b, 8'h09), gmul(b, 8'h0e)};
    else          t = {gmul(b, 8'h03), b, b, gmul(b, 8'h02)};
    r = rs2;
    for (int i = 0; i < 4; i++) r[8*((i + int'(bs)) % 4) +: 8] ^= t[8*i +: 8];
    return r;
  endfunction

  // Whole-column AES round: (Inv)SubBytes, optional (Inv)MixColumns matrix product, ^ rk.
  function automatic logic [31:0] ref_col(input logic dec, input logic last,
                                          input logic [31:0] col, input logic [31:0] rk);
    logic [7:0] s[4];
    logic [7:0] m[4];
    logic [7:0] row[4];
    if (dec) row = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     row = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int c = 0; c < 4; c++) s[c] = dec ? inv_sbox[col[8*c +: 8]] : sbox[col[8*c +: 8]];
    for (int r = 0; r < 4; r++) begin
      m[r] = 8'h00;
      if (last) m[r] = s[r];
      else for (int c = 0; c < 4; c++) m[r] ^= gmul(row[(c - r + 4) % 4], s[c]);
    end
    return {m[3], m[2], m[1], m[0]} ^ rk;
  endfunction

  // ---------------- DUTs ----------------
  for (genvar g = 0; g < 2; g++) begin : g_inst
    aes_v3_col_seq #(.PIPE_RD(g == 1)) u_dut (
      .g_clk      (g_clk),
      .g_resetn   (g_resetn),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_dec    (req_dec[g]),
      .req_last   (req_last[g]),
      .req_col    (req_col[g]),
      .req_rk     (req_rk[g]),
      .rsp_valid  (rsp_valid[g]),
      .rsp_ready  (rsp_ready[g]),
      .rsp_data   (rsp_data[g]),
      .busy       (busy[g]),
      .unit_valid (unit_valid[g]),
      .unit_dec   (unit_dec[g]),
      .unit_mix   (unit_mix[g]),
      .unit_bs    (unit_bs[g]),
      .unit_rs1   (unit_rs1[g]),
      .unit_rs2   (unit_rs2[g]),
      .unit_rd    (unit_rd[g])
    );
    assign unit_rd[g] = unit_op(unit_dec[g], unit_mix[g], unit_bs[g], unit_rs1[g], unit_rs2[g]);
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  always @(negedge g_clk) begin
    for (int k = 0; k < 2; k++) begin
      if (unit_valid[k]) op_cnt[k]++;
      if (rsp_valid[k] && !prev_v[k]) begin
        if (due_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rsp_unexpected: inst %0d got rsp_valid=1 want no response", k);
        end else begin
          check("rsp_latency_cycle", 32'(cyc), 32'(due_q.pop_front()));
          check("unit_issue_count", 32'(op_cnt[k]), 32'(ops_q.pop_front()));
        end
        op_cnt[k] = 0;
      end
      if (rsp_valid[k] && rsp_ready[k]) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rsp_data_unexpected: inst %0d got %h want nothing", k, rsp_data[k]);
        end else begin
          check("rsp_data", rsp_data[k], exp_q.pop_front());
        end
      end
      prev_v[k] = rsp_valid[k];
    end
  end

  always @(posedge g_clk) begin
    #2;
    if (rnd_rdy) for (int k = 0; k < 2; k++) rsp_ready[k] = 1'($urandom_range(0, 1));
  end

  // ---------------- driver tasks ----------------
  task automatic send(input int k, input logic dec, input logic last, input logic [31:0] col,
                      input logic [31:0] rk, input logic [31:0] want);
    int n;
    n = 0;
    @(negedge g_clk);
    req_valid[k] = 1'b1;
    req_dec[k]   = dec;
    req_last[k]  = last;
    req_col[k]   = col;
    req_rk[k]    = rk;
    while (!req_ready[k] && n < 200) begin
      @(negedge g_clk);
      n++;
    end
    check("req_accept", 32'(req_ready[k]), 32'd1);
    if (req_ready[k]) begin
      exp_q.push_back(want);
      if (k == 0) due_q.push_back(cyc + (last ? 5 : 9));
      else        due_q.push_back(cyc + (last ? 9 : 17));
      ops_q.push_back(last ? 4 : 8);
      @(posedge g_clk);
      #1;
    end
    req_valid[k] = 1'b0;
    req_dec[k]   = 1'($urandom_range(0, 1));
    req_last[k]  = 1'($urandom_range(0, 1));
    req_col[k]   = $urandom();
    req_rk[k]    = $urandom();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge g_clk);
      n++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_zero(input int k);
    check("zero_rsp_valid",  32'(rsp_valid[k]),  32'd0);
    check("zero_busy",       32'(busy[k]),       32'd0);
    check("zero_unit_valid", 32'(unit_valid[k]), 32'd0);
    check("zero_unit_dec",   32'(unit_dec[k]),   32'd0);
    check("zero_unit_mix",   32'(unit_mix[k]),   32'd0);
    check("zero_unit_bs",    32'(unit_bs[k]),    32'd0);
    check("zero_unit_rs1",   unit_rs1[k],        32'd0);
    check("zero_unit_rs2",   unit_rs2[k],        32'd0);
    check("zero_rsp_data",   rsp_data[k],        32'd0);
  endtask

  task automatic run_suite(input int k);
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic        d;
    logic        l;
    int          n;

    rsp_ready[k] = 1'b1;
    send(k, 1'b0, 1'b0, 32'h088df419, 32'h00000000, 32'he5816604);
    send(k, 1'b0, 1'b0, 32'h088df419, 32'h17fefaa0, 32'hf27f9ca4);
    send(k, 1'b0, 1'b1, 32'h088df419, 32'h00000000, 32'h305dbfd4);
    send(k, 1'b1, 1'b1, 32'h305dbfd4, 32'h00000000, 32'h088df419);
    send(k, 1'b0, 1'b0, 32'h00000000, 32'h00000000, 32'h63636363);
    send(k, 1'b1, 1'b0, 32'h00000000, 32'h00000000, 32'h52525252);
    drain();

    // Back-pressure: response held while a second request waits.
    c = $urandom();
    a = $urandom();
    rsp_ready[k] = 1'b0;
    send(k, 1'b1, 1'b0, c, a, ref_col(1'b1, 1'b0, c, a));
    n = 0;
    while (!rsp_valid[k] && n < 100) begin
      @(negedge g_clk);
      n++;
    end
    check("bp_rsp_valid_seen", 32'(rsp_valid[k]), 32'd1);
    b = $urandom();
    req_valid[k] = 1'b1;
    req_dec[k]   = 1'b0;
    req_last[k]  = 1'b0;
    req_col[k]   = b;
    req_rk[k]    = a;
    for (int i = 0; i < 10; i++) begin
      @(negedge g_clk);
      check("bp_rsp_data",   rsp_data[k], ref_col(1'b1, 1'b0, c, a));
      check("bp_rsp_valid",  32'(rsp_valid[k]), 32'd1);
      check("bp_req_ready",  32'(req_ready[k]), 32'd0);
      check("bp_unit_valid", 32'(unit_valid[k]), 32'd0);
      check("bp_unit_rs2",   unit_rs2[k], 32'd0);
    end
    rsp_ready[k] = 1'b1;
    send(k, 1'b0, 1'b0, b, a, ref_col(1'b0, 1'b0, b, a));
    drain();

    // Reset in the middle of the MixColumns phase.
    send(k, 1'b0, 1'b0, 32'h088df419, 32'h17fefaa0, 32'hf27f9ca4);
    n = 0;
    while (!(unit_mix[k] && unit_bs[k] == 2'd2) && n < 100) begin
      @(negedge g_clk);
      n++;
    end
    check("mid_mix_bs2_reached", 32'(unit_mix[k] && unit_bs[k] == 2'd2), 32'd1);
    g_resetn = 1'b0;
    #1;
    exp_q.delete();
    due_q.delete();
    ops_q.delete();
    op_cnt[k] = 0;
    check_zero(k);
    repeat (2) @(negedge g_clk);
    g_resetn = 1'b1;
    @(negedge g_clk);
    check("post_rst_req_ready", 32'(req_ready[k]), 32'd1);
    check("post_rst_busy",      32'(busy[k]),      32'd0);
    send(k, 1'b0, 1'b0, 32'h088df419, 32'h17fefaa0, 32'hf27f9ca4);
    send(k, 1'b1, 1'b1, 32'h305dbfd4, 32'h00000000, 32'h088df419);
    drain();

    // Random requests with random consumer stalls.
    rnd_rdy = 1'b1;
    for (int i = 0; i < 25; i++) begin
      d = 1'($urandom_range(0, 1));
      l = 1'($urandom_range(0, 1));
      c = $urandom();
      a = $urandom();
      send(k, d, l, c, a, ref_col(d, l, c, a));
    end
    rnd_rdy = 1'b0;
    @(posedge g_clk);
    #3;
    rsp_ready[k] = 1'b1;
    drain();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    total    = 0;
    bad      = 0;
    rnd_rdy  = 1'b0;
    g_resetn = 1'b0;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0;
      req_dec[k]   = 1'b0;
      req_last[k]  = 1'b0;
      req_col[k]   = 32'd0;
      req_rk[k]    = 32'd0;
      rsp_ready[k] = 1'b1;
      prev_v[k]    = 1'b0;
      op_cnt[k]    = 0;
    end
    build_sbox();
    repeat (3) @(negedge g_clk);
    for (int k = 0; k < 2; k++) check_zero(k);
    g_resetn = 1'b1;
    @(negedge g_clk);
    for (int k = 0; k < 2; k++) begin
      check("reset_req_ready", 32'(req_ready[k]), 32'd1);
      check("reset_busy",      32'(busy[k]),      32'd0);
    end
    run_suite(0);
    run_suite(1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
